// File: rtl/narrow_mem_responder.sv
// narrow_mem_responder: AXI4 subordinate endpoint on the narrow NI port.
// Serves reads and writes from an internal 64-bit word register file.
// Ports:
//   clk_i   clock
//   rst_ni  async active-low reset
//   req_i   AW/W/AR channels plus B/R ready, from the NI
//   rsp_o   AW/W/AR ready plus B/R channels, to the NI
//   busy_o  high while either the read or the write FSM is not idle
// Build option: define NARROW_RESP_RANGE_CHECK_EN to answer bursts whose
// start address lies outside [BaseAddr, BaseAddr+NumWords*8) with DECERR.

package narrow_mem_responder_pkg;

    localparam int unsigned AxiIdW = 4;

    typedef logic [AxiIdW-1:0] axi_id_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        axi_id_t     id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [5:0]  atop;
    } axi_aw_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        axi_id_t     id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ar_t;

    typedef struct packed {
        axi_id_t    id;
        logic [1:0] resp;
    } axi_b_t;

    typedef struct packed {
        axi_id_t     id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } axi_r_t;

    typedef struct packed {
        axi_aw_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_narrow_out_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_narrow_out_rsp_t;

endpackage

module narrow_mem_responder
    import narrow_mem_responder_pkg::*;
#(
    parameter int unsigned NumWords  = 1024,
    parameter logic [63:0] BaseAddr  = 64'h8000_0000,
    parameter int unsigned RdLatency = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  axi_narrow_out_req_t req_i,
    output axi_narrow_out_rsp_t rsp_o,
    output logic                busy_o
);

    localparam int unsigned IdxW = $clog2(NumWords);
    localparam logic [1:0] WaitInit =
        2'(RdLatency >= 2 ? RdLatency - 2 : 0);

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_DATA
    } rstate_e;

    function automatic logic [IdxW-1:0] f_idx(input logic [63:0] addr);
        return IdxW'((addr - BaseAddr) >> 3);
    endfunction

    // WRAP bursts advance like INCR.
    function automatic logic [63:0] f_step(input logic [1:0] burst,
                                           input logic [2:0] size);
        return (burst == BURST_FIXED) ? 64'd0 : (64'd1 << size);
    endfunction

    logic [63:0] r_mem [NumWords];

    wstate_e     r_wstate;
    axi_id_t     r_wid;
    logic [63:0] r_waddr;
    logic [7:0]  r_wlen;
    logic [2:0]  r_wsize;
    logic [1:0]  r_wburst;
    logic [7:0]  r_wcnt;
    logic        r_werr;

    rstate_e     r_rstate;
    axi_id_t     r_rid;
    logic [63:0] r_raddr;
    logic [7:0]  r_rlen;
    logic [2:0]  r_rsize;
    logic [1:0]  r_rburst;
    logic [7:0]  r_rcnt;
    logic        r_rerr;
    logic [1:0]  r_rwait;
    logic [63:0] r_rdata;

    logic            w_aw_ok;
    logic            w_ar_ok;
    logic            w_aw_hs;
    logic            w_w_hs;
    logic            w_w_done;
    logic            w_mem_we;
    logic [IdxW-1:0] w_widx;
    logic            w_ar_hs;
    logic            w_r_last;
    logic [63:0]     w_r_next;
    logic [IdxW-1:0] w_rd_idx;
    logic            w_rd_err;
    logic [63:0]     w_rd_word;

`ifdef NARROW_RESP_RANGE_CHECK_EN
    localparam logic [63:0] EndAddr = BaseAddr + 64'(NumWords) * 64'd8;
    assign w_aw_ok = (req_i.aw.addr >= BaseAddr) && (req_i.aw.addr < EndAddr);
    assign w_ar_ok = (req_i.ar.addr >= BaseAddr) && (req_i.ar.addr < EndAddr);
`else
    assign w_aw_ok = 1'b1;
    assign w_ar_ok = 1'b1;
`endif

    assign w_aw_hs  = req_i.aw_valid && (r_wstate == W_IDLE);
    assign w_w_hs   = req_i.w_valid && (r_wstate == W_DATA);
    // Early w.last or the len+1-th beat, whichever comes first.
    assign w_w_done = w_w_hs && (req_i.w.last || (r_wcnt == r_wlen));
    assign w_mem_we = w_w_hs && !r_werr;
    assign w_widx   = f_idx(r_waddr);

    assign w_ar_hs  = req_i.ar_valid && (r_rstate == R_IDLE);
    assign w_r_last = (r_rcnt == r_rlen);
    assign w_r_next = r_raddr + f_step(r_rburst, r_rsize);

    // Read port address: AR address at accept, latched address while
    // waiting, next beat address for the prefetch during R_DATA.
    always_comb begin
        w_rd_idx = f_idx(r_raddr);
        w_rd_err = r_rerr;
        case (r_rstate)
            R_IDLE: begin
                w_rd_idx = f_idx(req_i.ar.addr);
                w_rd_err = !w_ar_ok;
            end
            R_DATA:  w_rd_idx = f_idx(w_r_next);
            default: w_rd_idx = f_idx(r_raddr);
        endcase
    end

    // Non-blocking memory update means a same-cycle prefetch sees old data.
    assign w_rd_word = w_rd_err ? 64'd0 : r_mem[w_rd_idx];

    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (req_i.w.strb[b]) begin
                    r_mem[w_widx][8*b +: 8] <= req_i.w.data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wstate <= W_IDLE;
            r_wid    <= '0;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_wid    <= req_i.aw.id;
                        r_waddr  <= req_i.aw.addr;
                        r_wlen   <= req_i.aw.len;
                        r_wsize  <= req_i.aw.size;
                        r_wburst <= req_i.aw.burst;
                        r_wcnt   <= '0;
                        r_werr   <= !w_aw_ok;
                        r_wstate <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_done) begin
                        r_wstate <= W_RESP;
                    end else if (w_w_hs) begin
                        r_wcnt  <= r_wcnt + 8'd1;
                        r_waddr <= r_waddr + f_step(r_wburst, r_wsize);
                    end
                end
                W_RESP: begin
                    if (req_i.b_ready) begin
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rstate <= R_IDLE;
            r_rid    <= '0;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
            r_rcnt   <= '0;
            r_rerr   <= 1'b0;
            r_rwait  <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rid    <= req_i.ar.id;
                        r_raddr  <= req_i.ar.addr;
                        r_rlen   <= req_i.ar.len;
                        r_rsize  <= req_i.ar.size;
                        r_rburst <= req_i.ar.burst;
                        r_rcnt   <= '0;
                        r_rerr   <= !w_ar_ok;
                        r_rwait  <= WaitInit;
                        // Latency 1 loads the first beat at accept time.
                        if (RdLatency <= 1) begin
                            r_rdata  <= w_rd_word;
                            r_rstate <= R_DATA;
                        end else begin
                            r_rstate <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_rwait == 2'd0) begin
                        r_rdata  <= w_rd_word;
                        r_rstate <= R_DATA;
                    end else begin
                        r_rwait <= r_rwait - 2'd1;
                    end
                end
                R_DATA: begin
                    if (req_i.r_ready) begin
                        if (w_r_last) begin
                            r_rstate <= R_IDLE;
                        end else begin
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_raddr <= w_r_next;
                            r_rdata <= w_rd_word;
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        rsp_o          = '0;
        rsp_o.aw_ready = (r_wstate == W_IDLE);
        rsp_o.w_ready  = (r_wstate == W_DATA);
        rsp_o.b_valid  = (r_wstate == W_RESP);
        rsp_o.b.id     = r_wid;
        rsp_o.b.resp   = r_werr ? RESP_DECERR : RESP_OKAY;
        rsp_o.ar_ready = (r_rstate == R_IDLE);
        rsp_o.r_valid  = (r_rstate == R_DATA);
        rsp_o.r.id     = r_rid;
        rsp_o.r.data   = r_rdata;
        rsp_o.r.resp   = r_rerr ? RESP_DECERR : RESP_OKAY;
        rsp_o.r.last   = w_r_last;
    end

    assign busy_o = (r_wstate != W_IDLE) || (r_rstate != R_IDLE);

    a_no_atop: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        w_aw_hs |-> (req_i.aw.atop == 6'd0)
    );

endmodule

// File: tb/tb_narrow_mem_responder.sv
// tb_narrow_mem_responder: directed scoreboard bench for narrow_mem_responder.
// Expected B/R responses are queued at issue time and popped by a monitor.

module tb_narrow_mem_responder;
    import narrow_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_narrow_out_req_t req;
    axi_narrow_out_rsp_t rsp;
    logic                busy;

    narrow_mem_responder #(
        .NumWords (1024),
        .BaseAddr (64'h8000_0000),
        .RdLatency(1)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .req_i (req),
        .rsp_o (rsp),
        .busy_o(busy)
    );

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct {
        logic [3:0]  id;
        logic [1:0]  resp;
        logic [63:0] data;
        logic        last;
    } r_exp_t;

    b_exp_t bq[$];
    r_exp_t rq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int rr_mode = 2;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // r_ready: 0 = always 1, 1 = toggle every cycle, 2 = held low
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rr_mode)
                0:       req.r_ready = 1'b1;
                1:       req.r_ready = ~req.r_ready;
                default: req.r_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp.b_valid && req.b_ready) begin
                if (bq.size() == 0) begin
                    check("b_unexpected", 1, 0);
                end else begin
                    b_exp_t e;
                    e = bq.pop_front();
                    check("b_id", 64'(rsp.b.id), 64'(e.id));
                    check("b_resp", 64'(rsp.b.resp), 64'(e.resp));
                end
            end
            if (rsp.r_valid && req.r_ready) begin
                if (rq.size() == 0) begin
                    check("r_unexpected", 1, 0);
                end else begin
                    r_exp_t e;
                    e = rq.pop_front();
                    check("r_data", rsp.r.data, e.data);
                    check("r_id", 64'(rsp.r.id), 64'(e.id));
                    check("r_resp", 64'(rsp.r.resp), 64'(e.resp));
                    check("r_last", 64'(rsp.r.last), 64'(e.last));
                end
            end else if (rsp.r_valid && rq.size() != 0) begin
                check("r_stall_data", rsp.r.data, rq[0].data);
            end
        end
    end

    task automatic send_aw(input logic [63:0] addr, input logic [3:0] id,
                           input logic [7:0] len, output time t);
        int n;
        @(posedge clk);
        #1;
        req.aw       = '0;
        req.aw.addr  = addr;
        req.aw.id    = id;
        req.aw.len   = len;
        req.aw.size  = 3'd3;
        req.aw.burst = 2'b01;
        req.aw_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rsp.aw_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!rsp.aw_ready) check("aw_timeout", 0, 1);
        @(posedge clk);
        t = $time;
        #1;
        req.aw_valid = 1'b0;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [3:0] id,
                            input logic [7:0] len, input logic [63:0] d[4],
                            input logic [7:0] s[4], input logic [1:0] resp,
                            output time t);
        int n;
        bq.push_back('{id: id, resp: resp});
        send_aw(addr, id, len, t);
        for (int i = 0; i <= int'(len); i++) begin
            req.w.data  = d[i];
            req.w.strb  = s[i];
            req.w.last  = (i == int'(len));
            req.w_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!rsp.w_ready && n < 200) begin
                n++;
                @(negedge clk);
            end
            if (!rsp.w_ready) check("w_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        req.w_valid = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input logic [63:0] d[4],
                           input logic [1:0] resp, output time t);
        int n;
        for (int i = 0; i <= int'(len); i++) begin
            rq.push_back('{id: id, resp: resp, data: d[i],
                           last: (i == int'(len))});
        end
        @(posedge clk);
        #1;
        req.ar       = '0;
        req.ar.addr  = addr;
        req.ar.id    = id;
        req.ar.len   = len;
        req.ar.size  = 3'd3;
        req.ar.burst = 2'b01;
        req.ar_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rsp.ar_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!rsp.ar_ready) check("ar_timeout", 0, 1);
        @(posedge clk);
        t = $time;
        #1;
        req.ar_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        @(negedge clk);
        while ((bq.size() != 0 || rq.size() != 0 || busy) && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (bq.size() != 0 || rq.size() != 0 || busy) begin
            check("idle_timeout", 0, 1);
            bq.delete();
            rq.delete();
        end
    endtask

    localparam logic [7:0] FF = 8'hFF;

    logic [63:0] d_a, d_b, d_old, d_new, d_p, d_x;
    logic [63:0] exp5;
    logic [1:0]  resp5;
    logic [63:0] exp6_0, exp6_1;
    logic [1:0]  resp6;
    time         t_aw, t_ar;

    initial begin
        req = '0;
        req.b_ready = 1'b1;
        d_a   = 64'hA1A1_A2A2_A3A3_A4A4;
        d_b   = 64'hB1B1_B2B2_B3B3_B4B4;
        d_old = 64'h0102_0304_0506_0708;
        d_new = 64'hF0E0_D0C0_B0A0_9080;
        d_p   = 64'h5555_6666_7777_8888;
        d_x   = 64'h0BAD_F00D_0000_2000;
`ifdef NARROW_RESP_RANGE_CHECK_EN
        resp5  = RESP_DECERR;
        exp5   = d_p;
        resp6  = RESP_DECERR;
        exp6_0 = 64'd0;
        exp6_1 = 64'd0;
`else
        resp5  = RESP_OKAY;
        exp5   = d_x;
        resp6  = RESP_OKAY;
        exp6_0 = d_a;
        exp6_1 = d_b;
`endif

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_r_valid", 64'(rsp.r_valid), 0);
        check("rst_b_valid", 64'(rsp.b_valid), 0);
        check("rst_w_ready", 64'(rsp.w_ready), 0);
        check("rst_busy", 64'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_aw_ready", 64'(rsp.aw_ready), 1);
        check("rst_ar_ready", 64'(rsp.ar_ready), 1);

        // 1: reset in the middle of a stalled read and an open write
        req.ar       = '0;
        req.ar.addr  = 64'h8000_0000;
        req.ar.len   = 8'd3;
        req.ar.size  = 3'd3;
        req.ar.burst = 2'b01;
        req.ar_valid = 1'b1;
        req.aw       = '0;
        req.aw.addr  = 64'h8000_0000;
        req.aw.len   = 8'd3;
        req.aw.size  = 3'd3;
        req.aw.burst = 2'b01;
        req.aw_valid = 1'b1;
        @(posedge clk);
        #1;
        req.ar_valid = 1'b0;
        req.aw_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t1_r_valid_pre", 64'(rsp.r_valid), 1);
        check("t1_w_ready_pre", 64'(rsp.w_ready), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_r_valid_rst", 64'(rsp.r_valid), 0);
        check("t1_b_valid_rst", 64'(rsp.b_valid), 0);
        check("t1_w_ready_rst", 64'(rsp.w_ready), 0);
        check("t1_busy_rst", 64'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t1_aw_ready", 64'(rsp.aw_ready), 1);
        check("t1_ar_ready", 64'(rsp.ar_ready), 1);
        rr_mode = 0;
        @(posedge clk);

        // 2: single write then read
        do_write(64'h8000_0010, 4'd3, 8'd0,
                 '{64'hDEAD_BEEF_0123_4567, 0, 0, 0},
                 '{FF, 0, 0, 0}, RESP_OKAY, t_aw);
        wait_idle();
        do_read(64'h8000_0010, 4'd3, 8'd0,
                '{64'hDEAD_BEEF_0123_4567, 0, 0, 0}, RESP_OKAY, t_ar);
        wait_idle();

        // 3: burst with a partial strobe, read back with r_ready toggling
        do_write(64'h8000_0110, 4'd5, 8'd0,
                 '{64'hAAAA_BBBB_CCCC_DDDD, 0, 0, 0},
                 '{FF, 0, 0, 0}, RESP_OKAY, t_aw);
        wait_idle();
        do_write(64'h8000_0100, 4'd6, 8'd3,
                 '{64'h1010_1010_1010_1010, 64'h2020_2020_2020_2020,
                   64'h1111_2222_3333_4444, 64'h4040_4040_4040_4040},
                 '{FF, FF, 8'h0F, FF}, RESP_OKAY, t_aw);
        wait_idle();
        rr_mode = 1;
        do_read(64'h8000_0100, 4'd7, 8'd3,
                '{64'h1010_1010_1010_1010, 64'h2020_2020_2020_2020,
                  64'hAAAA_BBBB_3333_4444, 64'h4040_4040_4040_4040},
                RESP_OKAY, t_ar);
        wait_idle();
        rr_mode = 0;
        @(posedge clk);

        // 4: AW and AR to the same word in the same cycle
        do_write(64'h8000_0200, 4'd1, 8'd0, '{d_old, 0, 0, 0},
                 '{FF, 0, 0, 0}, RESP_OKAY, t_aw);
        wait_idle();
        fork
            do_write(64'h8000_0200, 4'd2, 8'd0, '{d_new, 0, 0, 0},
                     '{FF, 0, 0, 0}, RESP_OKAY, t_aw);
            do_read(64'h8000_0200, 4'd4, 8'd0, '{d_old, 0, 0, 0},
                    RESP_OKAY, t_ar);
        join
        check("t4_same_cycle_hs", 64'(t_aw), 64'(t_ar));
        wait_idle();
        do_read(64'h8000_0200, 4'd4, 8'd0, '{d_new, 0, 0, 0},
                RESP_OKAY, t_ar);
        wait_idle();

        // 5: index wrap and a burst crossing the end of the memory
        do_write(64'h8000_0000, 4'd1, 8'd0, '{d_p, 0, 0, 0},
                 '{FF, 0, 0, 0}, RESP_OKAY, t_aw);
        wait_idle();
        do_write(64'h8000_2000, 4'd1, 8'd0, '{d_x, 0, 0, 0},
                 '{FF, 0, 0, 0}, resp5, t_aw);
        wait_idle();
        do_read(64'h8000_0000, 4'd8, 8'd0, '{exp5, 0, 0, 0},
                RESP_OKAY, t_ar);
        wait_idle();
        do_write(64'h8000_1FF8, 4'd2, 8'd1, '{d_a, d_b, 0, 0},
                 '{FF, FF, 0, 0}, RESP_OKAY, t_aw);
        wait_idle();
        do_read(64'h8000_1FF8, 4'd2, 8'd1, '{d_a, d_b, 0, 0},
                RESP_OKAY, t_ar);
        wait_idle();

        // 6: start address below BaseAddr
        do_read(64'h7FFF_FFF8, 4'd9, 8'd1, '{exp6_0, exp6_1, 0, 0},
                resp6, t_ar);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
